// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM access stage and its lane logic.
// Optional bus timeout is enabled by defining MEM_BUS_TIMEOUT_EN.
package mem_access_stage_pkg;

   localparam logic ENABLE   = 1'b1;
   localparam logic DISABLE  = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Reset is asynchronous, taken on the falling edge, active low
   localparam logic RESET_EDGE   = 1'b0;
   localparam logic RESET_ENABLE = 1'b0;

   localparam logic [1:0] CTRL_OP_NOP = 2'd0;

   localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
   localparam logic [2:0] ISA_EXP_BUS_ERR    = 3'd7;

   typedef enum logic [3:0] {
      MEM_OP_NOP = 4'd0,
      MEM_OP_LW  = 4'd1,
      MEM_OP_LH  = 4'd2,
      MEM_OP_LHU = 4'd3,
      MEM_OP_LB  = 4'd4,
      MEM_OP_LBU = 4'd5,
      MEM_OP_SW  = 4'd6,
      MEM_OP_SH  = 4'd7,
      MEM_OP_SB  = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM access stage and the memory.
// The stage side is master; the memory side is slave.
interface mem_access_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [3:0]        be;
   logic [DATA_W-1:0] rd_data;
   logic              rdy;

   modport master (
      output req, rw, addr, wr_data, be,
      input  rd_data, rdy
   );

   modport slave (
      input  req, rw, addr, wr_data, be,
      output rd_data, rdy
   );
endinterface

// File: rtl/mem_lane_ctrl.sv
// Alignment check, store byte lanes and load extraction.
// Purely combinational; lanes are little-endian.
module mem_lane_ctrl
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  mem_op_t           op,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] wr_data,
   input  mem_op_t           ld_op,
   input  logic [1:0]        ld_off,
   input  logic [DATA_W-1:0] rd_data,
   output logic              access,
   output logic              is_load,
   output logic              miss_align,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wr_lanes,
   output logic [DATA_W-1:0] ld_data
);

   logic       is_w;
   logic       is_h;
   logic       is_b;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   always_comb begin
      is_w = op inside {MEM_OP_LW, MEM_OP_SW};
      is_h = op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH};
      is_b = op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB};
      access  = is_w | is_h | is_b;
      is_load = op inside {MEM_OP_LW, MEM_OP_LH, MEM_OP_LHU,
                           MEM_OP_LB, MEM_OP_LBU};
      miss_align = (is_w && off != 2'b00) || (is_h && off[0]);
      be       = 4'b0000;
      wr_lanes = '0;
      unique case (1'b1)
         is_w: begin
            be       = 4'b1111;
            wr_lanes = wr_data;
         end
         is_h: begin
            be       = off[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wr_data[15:0]}};
         end
         is_b: begin
            be       = 4'b0001 << off;
            wr_lanes = {4{wr_data[7:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_b    = rd_data[{ld_off, 3'b000} +: 8];
      ld_h    = ld_off[1] ? rd_data[31:16] : rd_data[15:0];
      ld_data = rd_data;
      unique case (ld_op)
         MEM_OP_LB:  ld_data = {{(DATA_W-8){ld_b[7]}}, ld_b};
         MEM_OP_LBU: ld_data = {{(DATA_W-8){1'b0}}, ld_b};
         MEM_OP_LH:  ld_data = {{(DATA_W-16){ld_h[15]}}, ld_h};
         MEM_OP_LHU: ld_data = {{(DATA_W-16){1'b0}}, ld_h};
         default:    ld_data = rd_data;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: MEM/WB register plus data-memory access FSM.
// Define MEM_BUS_TIMEOUT_EN to turn a stuck bus into a bus error.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CTRL_OP_W  = 2,
   parameter int EXP_W      = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     ex_pc,
   input  logic                  ex_en,
   input  logic                  ex_br_flag,
   input  logic [CTRL_OP_W-1:0]  ex_ctrl_op,
   input  logic [REG_ADDR_W-1:0] ex_dst_addr,
   input  logic                  ex_gpr_we_,
   input  logic [EXP_W-1:0]      ex_exp_code,
   input  logic [3:0]            ex_mem_op,
   input  logic [ADDR_W-1:0]     ex_addr,
   input  logic [DATA_W-1:0]     ex_wr_data,
   mem_access_stage_if.master    bus,
   output logic                  busy,
   output logic [ADDR_W-1:0]     mem_pc,
   output logic                  mem_en,
   output logic                  mem_br_flag,
   output logic [CTRL_OP_W-1:0]  mem_ctrl_op,
   output logic [REG_ADDR_W-1:0] mem_dst_addr,
   output logic                  mem_gpr_we_,
   output logic [EXP_W-1:0]      mem_exp_code,
   output logic [DATA_W-1:0]     mem_out
);

   typedef struct packed {
      logic [ADDR_W-1:0]     pc;
      logic                  en;
      logic                  br_flag;
      logic [CTRL_OP_W-1:0]  ctrl_op;
      logic [REG_ADDR_W-1:0] dst_addr;
      logic                  gpr_we_;
      logic [EXP_W-1:0]      exp_code;
      logic [DATA_W-1:0]     out;
   } wb_t;

   localparam wb_t BUBBLE = '{
      pc:       '0,
      en:       DISABLE,
      br_flag:  DISABLE,
      ctrl_op:  CTRL_OP_W'(CTRL_OP_NOP),
      dst_addr: '0,
      gpr_we_:  DISABLE_,
      exp_code: EXP_W'(ISA_EXP_NO_EXP),
      out:      '0
   };

   state_t            state_q, state_n;
   wb_t               wb_q, wb_n;
   wb_t               lat_q, lat_n;
   wb_t               hold_q, hold_n;
   wb_t               ex_wb, res;
   mem_op_t           ex_op;
   mem_op_t           lat_op_q, lat_op_n;
   logic [1:0]        lat_off_q, lat_off_n;
   logic              kill_q, kill_n;
   logic              req_q, req_n;
   logic              rw_q, rw_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wd_q, wd_n;
   logic [3:0]        be_q, be_n;
   logic              access, is_load, miss;
   logic [3:0]        be_l;
   logic [DATA_W-1:0] wd_l, ld_data;
   logic              offered, timeout, done;

   assign ex_op = mem_op_t'(ex_mem_op);

   mem_lane_ctrl #(.DATA_W(DATA_W)) u_lane (
      .op         (ex_op),
      .off        (ex_addr[1:0]),
      .wr_data    (ex_wr_data),
      .ld_op      (lat_op_q),
      .ld_off     (lat_off_q),
      .rd_data    (bus.rd_data),
      .access     (access),
      .is_load    (is_load),
      .miss_align (miss),
      .be         (be_l),
      .wr_lanes   (wd_l),
      .ld_data    (ld_data)
   );

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;

   // Counter sits at zero outside WAIT, so it restarts on every entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              cnt_q <= '0;
      else if (state_q != WAIT) cnt_q <= '0;
      else                     cnt_q <= cnt_q + 1'b1;
   end

   assign timeout = (state_q == WAIT) && !bus.rdy &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign timeout = 1'b0;
`endif

   assign offered = ex_en && access;
   assign done    = bus.rdy || timeout;
   assign busy    = (state_q == IDLE && offered && !miss && !stall) ||
                    (state_q != IDLE);

   always_comb begin
      ex_wb.pc       = ex_pc;
      ex_wb.en       = ex_en;
      ex_wb.br_flag  = ex_br_flag;
      ex_wb.ctrl_op  = ex_ctrl_op;
      ex_wb.dst_addr = ex_dst_addr;
      ex_wb.gpr_we_  = ex_gpr_we_;
      ex_wb.exp_code = ex_exp_code;
      ex_wb.out      = ex_addr;

      res = lat_q;
      if (rw_q) res.out     = ld_data;
      else      res.gpr_we_ = DISABLE_;
      if (timeout) begin
         res.ctrl_op  = CTRL_OP_W'(CTRL_OP_NOP);
         res.gpr_we_  = DISABLE_;
         res.exp_code = EXP_W'(ISA_EXP_BUS_ERR);
         res.out      = '0;
      end

      state_n   = state_q;
      wb_n      = wb_q;
      lat_n     = lat_q;
      hold_n    = hold_q;
      lat_op_n  = lat_op_q;
      lat_off_n = lat_off_q;
      kill_n    = kill_q;
      req_n     = req_q;
      rw_n      = rw_q;
      addr_n    = addr_q;
      wd_n      = wd_q;
      be_n      = be_q;

      unique case (state_q)
         IDLE: begin
            if (!stall) begin
               if (flush) begin
                  wb_n = BUBBLE;
               end else if (offered && miss) begin
                  wb_n          = BUBBLE;
                  wb_n.pc       = ex_pc;
                  wb_n.en       = ex_en;
                  wb_n.br_flag  = ex_br_flag;
                  wb_n.exp_code = EXP_W'(ISA_EXP_MISS_ALIGN);
               end else if (offered) begin
                  wb_n      = BUBBLE;
                  lat_n     = ex_wb;
                  lat_op_n  = ex_op;
                  lat_off_n = ex_addr[1:0];
                  kill_n    = 1'b0;
                  req_n     = 1'b1;
                  rw_n      = is_load;
                  addr_n    = {ex_addr[ADDR_W-1:2], 2'b00};
                  wd_n      = wd_l;
                  be_n      = be_l;
                  state_n   = WAIT;
               end else begin
                  wb_n = ex_wb;
               end
            end
         end
         WAIT: begin
            if (flush) kill_n = 1'b1;
            if (done) begin
               req_n   = 1'b0;
               kill_n  = 1'b0;
               state_n = IDLE;
               if (kill_q || flush) begin
                  wb_n = BUBBLE;
               end else if (!stall) begin
                  wb_n = res;
               end else begin
                  hold_n  = res;
                  state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (flush) begin
               wb_n    = BUBBLE;
               state_n = IDLE;
            end else if (!stall) begin
               wb_n    = hold_q;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_q      <= BUBBLE;
         lat_q     <= '0;
         hold_q    <= '0;
         lat_op_q  <= MEM_OP_NOP;
         lat_off_q <= 2'b00;
         kill_q    <= 1'b0;
         req_q     <= 1'b0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wd_q      <= '0;
         be_q      <= 4'b0000;
      end else begin
         wb_q      <= wb_n;
         lat_q     <= lat_n;
         hold_q    <= hold_n;
         lat_op_q  <= lat_op_n;
         lat_off_q <= lat_off_n;
         kill_q    <= kill_n;
         req_q     <= req_n;
         rw_q      <= rw_n;
         addr_q    <= addr_n;
         wd_q      <= wd_n;
         be_q      <= be_n;
      end
   end

   assign bus.req     = req_q;
   assign bus.rw      = rw_q;
   assign bus.addr    = addr_q;
   assign bus.wr_data = wd_q;
   assign bus.be      = be_q;

   assign mem_pc       = wb_q.pc;
   assign mem_en       = wb_q.en;
   assign mem_br_flag  = wb_q.br_flag;
   assign mem_ctrl_op  = wb_q.ctrl_op;
   assign mem_dst_addr = wb_q.dst_addr;
   assign mem_gpr_we_  = wb_q.gpr_we_;
   assign mem_exp_code = wb_q.exp_code;
   assign mem_out      = wb_q.out;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus
// hand sequences for stall, flush, reset and timeout.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush;
   logic [31:0] ex_pc;
   logic        ex_en, ex_br_flag;
   logic [1:0]  ex_ctrl_op;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_addr, ex_wr_data;
   logic        busy;
   logic [31:0] mem_pc;
   logic        mem_en, mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic        mem_gpr_we_;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .ex_pc        (ex_pc),
      .ex_en        (ex_en),
      .ex_br_flag   (ex_br_flag),
      .ex_ctrl_op   (ex_ctrl_op),
      .ex_dst_addr  (ex_dst_addr),
      .ex_gpr_we_   (ex_gpr_we_),
      .ex_exp_code  (ex_exp_code),
      .ex_mem_op    (ex_mem_op),
      .ex_addr      (ex_addr),
      .ex_wr_data   (ex_wr_data),
      .bus          (bus),
      .busy         (busy),
      .mem_pc       (mem_pc),
      .mem_en       (mem_en),
      .mem_br_flag  (mem_br_flag),
      .mem_ctrl_op  (mem_ctrl_op),
      .mem_dst_addr (mem_dst_addr),
      .mem_gpr_we_  (mem_gpr_we_),
      .mem_exp_code (mem_exp_code),
      .mem_out      (mem_out)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] exc);
      ex_en       = 1'b1;
      ex_mem_op   = op;
      ex_addr     = addr;
      ex_wr_data  = wd;
      ex_exp_code = exc;
   endtask

   // kind: 0 pass-through, 1 misaligned, 2 bus access
   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [2:0]  ex_exc;
      int          kind;
      logic [31:0] e_out;
      logic        e_we;
      logic [2:0]  e_exc;
      logic [1:0]  e_ctrl;
      logic [4:0]  e_dst;
      logic [3:0]  e_be;
      logic [31:0] e_bwd;
      logic        e_rw;
   } vec_t;

   vec_t vt[14];

   initial begin
      vt[0]  = '{MEM_OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 3'd0, 2,
                 32'hDEADBEEF, 1'b0, 3'd0, 2'd1, 5'd7, 4'hF, 32'h0, 1'b1};
      vt[1]  = '{MEM_OP_LB,  32'h103, 32'h0, 32'h80123456, 3'd0, 2,
                 32'hFFFFFF80, 1'b0, 3'd0, 2'd1, 5'd7, 4'h8, 32'h0, 1'b1};
      vt[2]  = '{MEM_OP_LBU, 32'h103, 32'h0, 32'h80123456, 3'd0, 2,
                 32'h00000080, 1'b0, 3'd0, 2'd1, 5'd7, 4'h8, 32'h0, 1'b1};
      vt[3]  = '{MEM_OP_LH,  32'h102, 32'h0, 32'h80123456, 3'd0, 2,
                 32'hFFFF8012, 1'b0, 3'd0, 2'd1, 5'd7, 4'hC, 32'h0, 1'b1};
      vt[4]  = '{MEM_OP_LHU, 32'h100, 32'h0, 32'h80123456, 3'd0, 2,
                 32'h00003456, 1'b0, 3'd0, 2'd1, 5'd7, 4'h3, 32'h0, 1'b1};
      vt[5]  = '{MEM_OP_LB,  32'h101, 32'h0, 32'h80123456, 3'd0, 2,
                 32'h00000034, 1'b0, 3'd0, 2'd1, 5'd7, 4'h2, 32'h0, 1'b1};
      vt[6]  = '{MEM_OP_SH,  32'h102, 32'h0000ABCD, 32'h0, 3'd0, 2,
                 32'h102, 1'b1, 3'd0, 2'd1, 5'd7, 4'hC, 32'hABCDABCD, 1'b0};
      vt[7]  = '{MEM_OP_SB,  32'h101, 32'h000000A5, 32'h0, 3'd0, 2,
                 32'h101, 1'b1, 3'd0, 2'd1, 5'd7, 4'h2, 32'hA5A5A5A5, 1'b0};
      vt[8]  = '{MEM_OP_SW,  32'h104, 32'h12345678, 32'h0, 3'd0, 2,
                 32'h104, 1'b1, 3'd0, 2'd1, 5'd7, 4'hF, 32'h12345678, 1'b0};
      vt[9]  = '{MEM_OP_LW,  32'h101, 32'h0, 32'h0, 3'd3, 1,
                 32'h0, 1'b1, 3'd4, 2'd0, 5'd0, 4'h0, 32'h0, 1'b0};
      vt[10] = '{MEM_OP_SH,  32'h103, 32'h0, 32'h0, 3'd0, 1,
                 32'h0, 1'b1, 3'd4, 2'd0, 5'd0, 4'h0, 32'h0, 1'b0};
      vt[11] = '{MEM_OP_LH,  32'h101, 32'h0, 32'h0, 3'd0, 1,
                 32'h0, 1'b1, 3'd4, 2'd0, 5'd0, 4'h0, 32'h0, 1'b0};
      vt[12] = '{MEM_OP_NOP, 32'h55, 32'h0, 32'h0, 3'd3, 0,
                 32'h55, 1'b0, 3'd3, 2'd1, 5'd7, 4'h0, 32'h0, 1'b0};
      vt[13] = '{MEM_OP_SB,  32'h103, 32'h00000077, 32'h0, 3'd0, 2,
                 32'h103, 1'b1, 3'd0, 2'd1, 5'd7, 4'h8, 32'h77777777, 1'b0};

      reset       = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      ex_pc       = 32'h40;
      ex_en       = 1'b0;
      ex_br_flag  = 1'b0;
      ex_ctrl_op  = 2'd1;
      ex_dst_addr = 5'd7;
      ex_gpr_we_  = 1'b0;
      ex_exp_code = 3'd0;
      ex_mem_op   = MEM_OP_NOP;
      ex_addr     = 32'h0;
      ex_wr_data  = 32'h0;
      bus.rd_data = 32'h0;
      bus.rdy     = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst mem_pc", mem_pc, 32'h0);
      chk("rst mem_en", mem_en, 0);
      chk("rst ctrl_op", mem_ctrl_op, CTRL_OP_NOP);
      chk("rst gpr_we_", mem_gpr_we_, 1);
      chk("rst exp", mem_exp_code, ISA_EXP_NO_EXP);
      chk("rst mem_out", mem_out, 32'h0);
      chk("rst req", bus.req, 0);
      chk("rst be", bus.be, 0);
      chk("rst busy", busy, 0);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vt[i].op, vt[i].addr, vt[i].wd, vt[i].ex_exc);
         bus.rd_data = vt[i].rd;
         bus.rdy     = 1'b1;
         #1 chk($sformatf("v%0d busy", i), busy, vt[i].kind == 2);
         @(negedge clk);
         if (vt[i].kind == 2) begin
            chk($sformatf("v%0d req", i), bus.req, 1);
            chk($sformatf("v%0d rw", i), bus.rw, vt[i].e_rw);
            chk($sformatf("v%0d addr", i), bus.addr,
                {vt[i].addr[31:2], 2'b00});
            chk($sformatf("v%0d busy wait", i), busy, 1);
            chk($sformatf("v%0d bubble", i), mem_en, 0);
            if (!vt[i].e_rw) begin
               chk($sformatf("v%0d be", i), bus.be, vt[i].e_be);
               chk($sformatf("v%0d wdata", i), bus.wr_data, vt[i].e_bwd);
            end
            @(negedge clk);
         end
         chk($sformatf("v%0d out", i), mem_out, vt[i].e_out);
         chk($sformatf("v%0d we_", i), mem_gpr_we_, vt[i].e_we);
         chk($sformatf("v%0d exp", i), mem_exp_code, vt[i].e_exc);
         chk($sformatf("v%0d ctrl", i), mem_ctrl_op, vt[i].e_ctrl);
         chk($sformatf("v%0d dst", i), mem_dst_addr, vt[i].e_dst);
         chk($sformatf("v%0d pc", i), mem_pc, 32'h40);
         chk($sformatf("v%0d en", i), mem_en, 1);
         chk($sformatf("v%0d req off", i), bus.req, 0);
         ex_en     = 1'b0;
         ex_mem_op = MEM_OP_NOP;
         bus.rdy   = 1'b0;
      end

      // stall held through the ready cycle and two more
      @(negedge clk);
      drive(MEM_OP_LW, 32'h200, 32'h0, 3'd0);
      bus.rd_data = 32'hCAFEF00D;
      @(negedge clk);
      chk("stall wait busy", busy, 1);
      bus.rdy = 1'b1;
      stall   = 1'b1;
      @(negedge clk);
      bus.rdy = 1'b0;
      chk("stall req drop", bus.req, 0);
      chk("stall hold en", mem_en, 0);
      chk("stall hold busy", busy, 1);
      @(negedge clk);
      chk("stall hold en2", mem_en, 0);
      @(negedge clk);
      chk("stall hold out", mem_out, 32'h0);
      stall = 1'b0;
      @(negedge clk);
      chk("stall result", mem_out, 32'hCAFEF00D);
      chk("stall en", mem_en, 1);
      chk("stall we_", mem_gpr_we_, 0);
      ex_en = 1'b0;

      // flush during WAIT on a store
      @(negedge clk);
      drive(MEM_OP_SW, 32'h300, 32'h11223344, 3'd0);
      @(negedge clk);
      chk("fl req", bus.req, 1);
      chk("fl rw", bus.rw, 0);
      chk("fl wdata", bus.wr_data, 32'h11223344);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl req kept", bus.req, 1);
      chk("fl busy", busy, 1);
      bus.rdy = 1'b1;
      @(negedge clk);
      bus.rdy = 1'b0;
      ex_en   = 1'b0;
      chk("fl req done", bus.req, 0);
      chk("fl bubble en", mem_en, 0);
      chk("fl bubble we_", mem_gpr_we_, 1);
      chk("fl bubble out", mem_out, 32'h0);

      // flush and ready in the same cycle
      @(negedge clk);
      drive(MEM_OP_LW, 32'h104, 32'h0, 3'd0);
      bus.rd_data = 32'h99;
      @(negedge clk);
      flush   = 1'b1;
      bus.rdy = 1'b1;
      @(negedge clk);
      flush   = 1'b0;
      bus.rdy = 1'b0;
      ex_en   = 1'b0;
      chk("flrdy en", mem_en, 0);
      chk("flrdy out", mem_out, 32'h0);
      chk("flrdy req", bus.req, 0);
      #1 chk("flrdy idle", busy, 0);

      // reset asserted mid-WAIT
      @(negedge clk);
      drive(MEM_OP_LW, 32'h108, 32'h0, 3'd0);
      repeat (2) @(negedge clk);
      chk("rstw req", bus.req, 1);
      reset = 1'b0;
      #1;
      chk("rstw req drop", bus.req, 0);
      chk("rstw addr", bus.addr, 32'h0);
      chk("rstw be", bus.be, 0);
      chk("rstw we_", mem_gpr_we_, 1);
      chk("rstw en", mem_en, 0);
      ex_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;

`ifdef MEM_BUS_TIMEOUT_EN
      @(negedge clk);
      drive(MEM_OP_LW, 32'h10C, 32'h0, 3'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("to req c%0d", k), bus.req, 1);
      end
      @(negedge clk);
      ex_en = 1'b0;
      chk("to req drop", bus.req, 0);
      chk("to exp", mem_exp_code, ISA_EXP_BUS_ERR);
      chk("to ctrl", mem_ctrl_op, CTRL_OP_NOP);
      chk("to we_", mem_gpr_we_, 1);
      chk("to out", mem_out, 32'h0);
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
